// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's request, response and RAM-side signals.
// The slave modport is the arbiter itself. The master modport is the
// surrounding pipeline stages and the RAM that drive it.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 17
) ();
  logic                  if_req_i;
  logic [31:0]           if_addr_i;
  logic                  if_flush_i;
  logic [31:0]           if_data_o;
  logic                  if_done_o;
  logic                  mem_req_i;
  logic                  mem_we_i;
  logic [1:0]            mem_len_i;
  logic [31:0]           mem_addr_i;
  logic [31:0]           mem_wdata_i;
  logic [31:0]           mem_rdata_o;
  logic                  mem_done_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic                  ram_wr_o;
  logic [7:0]            ram_dout_o;
  logic [7:0]            ram_din_i;
  logic                  stallreq_if_o;
  logic                  stallreq_mem_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o,
    output ram_addr_o, ram_wr_o, ram_dout_o,
    output stallreq_if_o, stallreq_mem_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o,
    input  ram_addr_o, ram_wr_o, ram_dout_o,
    input  stallreq_if_o, stallreq_mem_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter that shares one byte-wide RAM port between instruction fetch
// and the data stage. Each access is split into 1/2/4 byte beats, and
// read bytes are assembled little-endian.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter bit MEM_FIRST  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t                state_reg, state_next;
  logic [2:0]            beat_reg, beat_next;
  logic [2:0]            len_reg, len_next;
  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic [31:0]           asm_reg, asm_next;
  logic [ADDR_WIDTH-1:0] ram_addr_reg, ram_addr_next;
  logic                  ram_wr_reg, ram_wr_next;
  logic [7:0]            ram_dout_reg, ram_dout_next;
  logic                  if_done_reg, if_done_next;
  logic                  mem_done_reg, mem_done_next;
  logic [31:0]           if_data_reg, if_data_next;
  logic [31:0]           mem_rdata_reg, mem_rdata_next;

  logic                  if_elig, mem_elig, grant_if, grant_mem;
  logic [2:0]            mem_n;
  logic                  last_beat;
  logic [2:0]            next_beat;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0]           asm_cap;
  logic                  unused_addr_bits;

  // A port that is in its done cycle, or an IF being flushed, may not be granted.
  assign if_elig   = bus.if_req_i && !if_done_reg && !bus.if_flush_i;
  assign mem_elig  = bus.mem_req_i && !mem_done_reg;
  assign grant_mem = mem_elig && (MEM_FIRST || !if_elig);
  assign grant_if  = if_elig && !grant_mem;

  assign mem_n     = (bus.mem_len_i == 2'd0) ? 3'd1 :
                     (bus.mem_len_i == 2'd1) ? 3'd2 : 3'd4;
  assign last_beat = (beat_reg == len_reg - 3'd1);
  assign next_beat = beat_reg + 3'd1;
  assign next_addr = base_reg + ADDR_WIDTH'(next_beat);
  // The byte arriving now belongs to the beat whose address went out last cycle.
  assign asm_cap   = asm_reg | ({24'd0, bus.ram_din_i} << {beat_reg[1:0], 3'b000});

  assign unused_addr_bits = ^{bus.if_addr_i[31:ADDR_WIDTH], bus.mem_addr_i[31:ADDR_WIDTH]};

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      beat_reg      <= 3'd0;
      len_reg       <= 3'd0;
      base_reg      <= '0;
      wdata_reg     <= 32'd0;
      asm_reg       <= 32'd0;
      ram_addr_reg  <= '0;
      ram_wr_reg    <= 1'b0;
      ram_dout_reg  <= 8'd0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
      if_data_reg   <= 32'd0;
      mem_rdata_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      len_reg       <= len_next;
      base_reg      <= base_next;
      wdata_reg     <= wdata_next;
      asm_reg       <= asm_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wr_reg    <= ram_wr_next;
      ram_dout_reg  <= ram_dout_next;
      if_done_reg   <= if_done_next;
      mem_done_reg  <= mem_done_next;
      if_data_reg   <= if_data_next;
      mem_rdata_reg <= mem_rdata_next;
    end
  end

  // Next-state selection: grant in IDLE, leave on the last beat or an IF flush.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_mem)     state_next = bus.mem_we_i ? MEM_WR : MEM_RD;
        else if (grant_if) state_next = IF_RD;
      end
      IF_RD:   if (bus.if_flush_i || last_beat) state_next = IDLE;
      MEM_RD:  if (last_beat) state_next = IDLE;
      MEM_WR:  if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat sequencing, byte capture and the registered RAM/done outputs.
  always_comb begin
    beat_next      = beat_reg;
    len_next       = len_reg;
    base_next      = base_reg;
    wdata_next     = wdata_reg;
    asm_next       = asm_reg;
    ram_addr_next  = ram_addr_reg;
    ram_wr_next    = 1'b0;
    ram_dout_next  = ram_dout_reg;
    if_done_next   = 1'b0;
    mem_done_next  = 1'b0;
    if_data_next   = if_data_reg;
    mem_rdata_next = mem_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (grant_mem) begin
          base_next     = bus.mem_addr_i[ADDR_WIDTH-1:0];
          len_next      = mem_n;
          wdata_next    = bus.mem_wdata_i;
          beat_next     = 3'd0;
          asm_next      = 32'd0;
          ram_addr_next = bus.mem_addr_i[ADDR_WIDTH-1:0];
          ram_wr_next   = bus.mem_we_i;
          ram_dout_next = bus.mem_wdata_i[7:0];
        end else if (grant_if) begin
          base_next     = bus.if_addr_i[ADDR_WIDTH-1:0];
          len_next      = 3'd4;
          beat_next     = 3'd0;
          asm_next      = 32'd0;
          ram_addr_next = bus.if_addr_i[ADDR_WIDTH-1:0];
        end
      end
      IF_RD: begin
        if (!bus.if_flush_i) begin
          asm_next = asm_cap;
          if (last_beat) begin
            if_done_next = 1'b1;
            if_data_next = asm_cap;
          end else begin
            beat_next     = next_beat;
            ram_addr_next = next_addr;
          end
        end
      end
      MEM_RD: begin
        asm_next = asm_cap;
        if (last_beat) begin
          mem_done_next  = 1'b1;
          mem_rdata_next = asm_cap;
        end else begin
          beat_next     = next_beat;
          ram_addr_next = next_addr;
        end
      end
      MEM_WR: begin
        if (last_beat) begin
          mem_done_next = 1'b1;
        end else begin
          beat_next     = next_beat;
          ram_addr_next = next_addr;
          ram_wr_next   = 1'b1;
          ram_dout_next = wdata_reg[{next_beat[1:0], 3'b000} +: 8];
        end
      end
      default: ;
    endcase
  end

  assign bus.if_data_o      = if_data_reg;
  assign bus.if_done_o      = if_done_reg;
  assign bus.mem_rdata_o    = mem_rdata_reg;
  assign bus.mem_done_o     = mem_done_reg;
  assign bus.ram_addr_o     = ram_addr_reg;
  assign bus.ram_wr_o       = ram_wr_reg;
  assign bus.ram_dout_o     = ram_dout_reg;
  assign bus.stallreq_if_o  = bus.if_req_i && !if_done_reg;
  assign bus.stallreq_mem_o = bus.mem_req_i && !mem_done_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random single-port
// transactions. Expected data comes from a byte-array memory image that is
// updated per completed store.
module tb_mem_arbiter;
  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] MASK = 32'(DEPTH - 1);

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .MEM_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model: read data reflects the registered address, writes on the strobe.
  logic [7:0]    ram [0:DEPTH-1];
  logic [7:0]    ref_mem [0:DEPTH-1];
  logic          poke_en;
  logic [AW-1:0] poke_addr;
  logic [7:0]    poke_data;

  assign bus.ram_din_i = ram[bus.ram_addr_o];

  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (bus.ram_wr_o) ram[bus.ram_addr_o] <= bus.ram_dout_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    poke_addr = AW'(a);
    poke_data = d;
    poke_en   = 1'b1;
    ref_mem[a & MASK] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] a, input int n);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++)
      v = v | (32'(ref_mem[(a + 32'(k)) & MASK]) << (8 * k));
    return v;
  endfunction

  function automatic logic get_done(input int port);
    return (port == 0) ? bus.if_done_o : bus.mem_done_o;
  endfunction

  function automatic logic get_stall(input int port);
    return (port == 0) ? bus.stallreq_if_o : bus.stallreq_mem_o;
  endfunction

  function automatic logic [31:0] get_data(input int port);
    return (port == 0) ? bus.if_data_o : bus.mem_rdata_o;
  endfunction

  // One complete access on one port, starting with the arbiter idle.
  task automatic run_txn(input int port, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    logic [31:0] exp;
    n   = (port == 0) ? 4 : ((len == 2'd0) ? 1 : ((len == 2'd1) ? 2 : 4));
    exp = exp_load(addr, n);
    if (port == 0) begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
    end else begin
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_len_i   = len;
      bus.mem_addr_i  = addr;
      bus.mem_wdata_i = wdata;
    end
    for (int e = 1; e <= n + 1; e++) begin
      @(posedge clk); #1;
      if (e <= n) begin
        check("ram_addr", 32'(bus.ram_addr_o), (addr + 32'(e - 1)) & MASK);
        check("ram_wr", 32'(bus.ram_wr_o), 32'(we));
        if (we) check("ram_dout", 32'(bus.ram_dout_o), 32'(wdata[8*(e-1) +: 8]));
        check("done_early", 32'(get_done(port)), 32'd0);
        check("stall_busy", 32'(get_stall(port)), 32'd1);
      end else begin
        check("done", 32'(get_done(port)), 32'd1);
        check("stall_done", 32'(get_stall(port)), 32'd0);
        check("ram_wr_end", 32'(bus.ram_wr_o), 32'd0);
        if (!we) check("rdata", get_data(port), exp);
        if (port == 0) bus.if_req_i = 1'b0;
        else bus.mem_req_i = 1'b0;
      end
    end
    if (we)
      for (int k = 0; k < n; k++) ref_mem[(addr + 32'(k)) & MASK] = wdata[8*k +: 8];
    @(posedge clk); #1;
    check("done_pulse", 32'(get_done(port)), 32'd0);
    $display("txn port=%0s we=%0d beats=%0d addr=%h wdata=%h data=%h",
             (port == 0) ? "IF" : "MEM", we, n, addr, wdata, get_data(port));
  endtask

  initial begin
    logic [31:0] a, low;
    int port;
    rst = 1'b1;
    poke_en = 1'b0;
    poke_addr = '0;
    poke_data = 8'd0;
    bus.if_req_i = 1'b0;    bus.if_addr_i = 32'd0;  bus.if_flush_i = 1'b0;
    bus.mem_req_i = 1'b0;   bus.mem_we_i = 1'b0;    bus.mem_len_i = 2'd0;
    bus.mem_addr_i = 32'd0; bus.mem_wdata_i = 32'd0;
    @(posedge clk); #1;

    // Preload both images while the arbiter is held in reset.
    for (int i = 0; i < 256; i++) poke(32'(i), 8'($urandom));
    for (int i = 0; i < 16; i++) poke(32'h1FFF0 + 32'(i), 8'($urandom));
    poke(32'h10, 8'h13); poke(32'h11, 8'h05); poke(32'h12, 8'h00); poke(32'h13, 8'h00);
    poke(32'h08, 8'hFF); poke(32'h09, 8'h80);

    check("rst_if_done", 32'(bus.if_done_o), 32'd0);
    check("rst_mem_done", 32'(bus.mem_done_o), 32'd0);
    check("rst_if_data", bus.if_data_o, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata_o, 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr_o), 32'd0);
    check("rst_ram_wr", 32'(bus.ram_wr_o), 32'd0);
    check("rst_ram_dout", 32'(bus.ram_dout_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(0, 1'b0, 2'd2, 32'h10, 32'd0);
    check("fetch_0x10", bus.if_data_o, 32'h00000513);
    run_txn(1, 1'b1, 2'd0, 32'h0001FFFF, 32'hABCD12EF);
    run_txn(1, 1'b1, 2'd1, 32'h0001FFFF, 32'hABCD12EF);
    run_txn(1, 1'b0, 2'd2, 32'h0001FFFF, 32'd0);
    run_txn(1, 1'b0, 2'd1, 32'h8, 32'd0);
    check("half_load_zext", bus.mem_rdata_o, 32'h000080FF);

    // Simultaneous requests: MEM first, IF granted in MEM's done cycle.
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 2'd2; bus.mem_addr_i = 32'h20;
    bus.if_req_i = 1'b1;  bus.if_addr_i = 32'h30;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      check("sim_stall_if", 32'(bus.stallreq_if_o), 32'(e < 10));
      check("sim_stall_mem", 32'(bus.stallreq_mem_o), 32'(e < 5 && bus.mem_req_i));
      check("sim_mem_done", 32'(bus.mem_done_o), 32'(e == 5));
      check("sim_if_done", 32'(bus.if_done_o), 32'(e == 10));
      if (e == 5) begin
        check("sim_mem_rdata", bus.mem_rdata_o, exp_load(32'h20, 4));
        bus.mem_req_i = 1'b0;
      end
      if (e == 10) begin
        check("sim_if_data", bus.if_data_o, exp_load(32'h30, 4));
        bus.if_req_i = 1'b0;
      end
    end
    @(posedge clk); #1;
    $display("txn simultaneous mem=20 if=30 done");

    // Flush two edges into a fetch, then refetch from the branch target.
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h50;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.if_flush_i = 1'b1; bus.if_addr_i = 32'h40;
    @(posedge clk); #1;
    check("flush_no_done", 32'(bus.if_done_o), 32'd0);
    bus.if_flush_i = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      check("flush_refetch_done", 32'(bus.if_done_o), 32'(e == 5));
      if (e == 5) begin
        check("flush_refetch_data", bus.if_data_o, exp_load(32'h40, 4));
        bus.if_req_i = 1'b0;
      end
    end
    @(posedge clk); #1;
    $display("txn flush refetch addr=40 data=%h", bus.if_data_o);

    // Reset while beat 2 of a word store is on the RAM port.
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'd2;
    bus.mem_addr_i = 32'h1000; bus.mem_wdata_i = 32'h11223344;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
    end
    check("mid_wr", 32'(bus.ram_wr_o), 32'd1);
    check("mid_addr", 32'(bus.ram_addr_o), 32'h1002);
    rst = 1'b1; bus.mem_req_i = 1'b0;
    @(posedge clk); #1;
    check("mrst_ram_wr", 32'(bus.ram_wr_o), 32'd0);
    check("mrst_ram_addr", 32'(bus.ram_addr_o), 32'd0);
    check("mrst_ram_dout", 32'(bus.ram_dout_o), 32'd0);
    check("mrst_mem_done", 32'(bus.mem_done_o), 32'd0);
    check("mrst_if_data", bus.if_data_o, 32'd0);
    check("mrst_mem_rdata", bus.mem_rdata_o, 32'd0);
    rst = 1'b0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      check("mrst_no_done", 32'(bus.mem_done_o), 32'd0);
    end
    $display("txn reset during word store");

    // Random single-port traffic, including addresses that wrap at the top.
    for (int i = 0; i < 40; i++) begin
      port = int'($urandom_range(0, 1));
      low  = ($urandom_range(0, 3) == 0) ? (32'h1FFF0 + 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 255));
      a    = ($urandom & ~MASK) | low;
      if (port == 0) run_txn(0, 1'b0, 2'd2, a, 32'd0);
      else run_txn(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide unified RAM port between instruction fetch (IF, via pc_reg) and the data-access stage (MEM).
- Serialises each 8/16/32-bit access into 1/2/4 byte beats and assembles read data little-endian.
- Drives stall requests to ctrl until the access completes.
- Sits between pc_reg/if_id, mem, ctrl and the external RAM.

Parameters:
ADDR_WIDTH, 17, RAM address width; byte addresses wrap modulo 2^ADDR_WIDTH.
MEM_FIRST, 1, 1 = MEM wins simultaneous requests in IDLE; 0 = IF wins.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
if_req_i  input  1  IF wants a 32-bit fetch
if_addr_i  input  32  fetch byte address
if_flush_i  input  1  branch taken; abandon any in-flight fetch
if_data_o  output  32  fetched instruction, valid when if_done_o
if_done_o  output  1  one-cycle fetch-complete pulse
mem_req_i  input  1  MEM wants an access
mem_we_i  input  1  1 = store, 0 = load
mem_len_i  input  2  0 = byte, 1 = half, 2 or 3 = word
mem_addr_i  input  32  data byte address
mem_wdata_i  input  32  store data, low bytes used
mem_rdata_o  output  32  load data, zero-extended, valid when mem_done_o
mem_done_o  output  1  one-cycle access-complete pulse
ram_addr_o  output  ADDR_WIDTH  RAM byte address (registered)
ram_wr_o  output  1  RAM write strobe (registered)
ram_dout_o  output  8  RAM write byte (registered)
ram_din_i  input  8  RAM read byte; valid the cycle after its address is presented
stallreq_if_o  output  1  to ctrl: if_req_i && !if_done_o (combinational)
stallreq_mem_o  output  1  to ctrl: mem_req_i && !mem_done_o (combinational)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, beat counter 0, ram_wr_o 0, ram_addr_o 0, ram_dout_o 0, if_done_o 0, mem_done_o 0, if_data_o 0, mem_rdata_o 0.
- A reset mid-operation drops ram_wr_o at that edge. The partial access is lost and no done pulse is issued.
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
- Grant (IDLE only), at edge E0:
  - Eligible requesters are those with req high and whose own done_o is not high this cycle. The done cycle never re-grants the same port; the other port may be granted.
  - Both eligible: MEM_FIRST selects the winner.
  - At grant, latch base address, N (IF always 4; MEM 1/2/4 from len), we and wdata. Later changes to the inputs are ignored.
- Beat k (k = 0..N-1): ram_addr_o <= base + k, truncated to ADDR_WIDTH and wrapping. Byte k occupies bits [8k+7:8k].
- Read (IF_RD, MEM_RD):
  - Addresses are issued at E0..E(N-1). Byte k is captured from ram_din_i at edge E(k+1).
  - At E(N): done_o <= 1 for exactly one cycle, data_o holds the assembled word, state returns to IDLE.
  - Unused upper bytes are 0. Word-read done is high in the cycle after E4.
- Write (MEM_WR):
  - ram_wr_o = 1 and ram_dout_o = byte k are driven during beats E0..E(N-1).
  - At E(N): ram_wr_o <= 0, mem_done_o <= 1 for one cycle, state returns to IDLE.
  - Load and store latency are identical: N+1 edges from grant to the done cycle.
- if_data_o / mem_rdata_o hold their value until the next completion on that port.
- Flush:
  - if_flush_i high in IF_RD: return to IDLE at the next edge, no if_done_o, captured bytes discarded.
  - if_flush_i high in IDLE with if_req_i: IF is not granted that edge.
  - Flush has no effect on MEM_RD or MEM_WR.
- No preemption: a request arriving while the other port is busy waits; its stallreq stays high.
- A requester deasserting req mid-access does not abort it (except an IF flush). The done pulse is still issued.
- Byte alignment is not checked. Misaligned half/word accesses simply use consecutive bytes.

Test Plan:
- IF-only fetch: addr 0x10, RAM[0x10..0x13] = 13,05,00,00 -> ram_addr_o 0x10..0x13 on consecutive cycles; if_done_o single pulse 5 edges after grant; if_data_o = 0x00000513; stallreq_if_o low in the done cycle.
- Byte store: mem_we=1, len=0, addr 0x1FFFF, wdata 0xABCD12EF -> one cycle ram_wr_o=1, ram_addr_o=0x1FFFF, ram_dout_o=0xEF; mem_done_o pulse at next edge.
- Half store at 0x1FFFF wraps: second beat ram_addr_o = 0x00000, ram_dout_o = 0x12.
- Simultaneous IF and MEM word load, MEM_FIRST=1: MEM served first; mem_done_o pulse; IF granted in that done cycle; if_done_o 5 edges later; stallreq_if_o high throughout.
- Flush: if_flush_i pulsed 2 edges into a fetch -> no if_done_o; next if_req_i with new addr 0x40 fetches from 0x40.
- Reset asserted during beat 2 of a word store -> ram_wr_o 0 next cycle; no mem_done_o; all outputs at reset values.
- Half load from 0x8, RAM = 0xFF,0x80 -> mem_rdata_o = 0x000080FF (zero-extended).
